// File: rtl/tnn_csr_seq_hs_pkg.sv
// Shared types and helpers for the CSR-sparse ternary classifier.
package tnn_pkg;

    // Widest packed parameter vector the field extractor can address.
    localparam int unsigned VEC_MAX = 4096;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L1   = 2'd1,
        S_L2   = 2'd2,
        S_DONE = 2'd3
    } tnn_state_e;

    // Index width for a dimension of n entries (never zero).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a pointer that can reach nnz inclusive.
    function automatic int unsigned ptr_w(input int unsigned nnz);
        return (nnz > 0) ? $clog2(nnz + 1) : 1;
    endfunction

    // Layer-1 accumulator: sum of up to N unsigned B-bit features, signed.
    function automatic int unsigned acc1_w(input int unsigned n, input int unsigned b);
        return b + $clog2(n + 1) + 1;
    endfunction

    // Layer-2 accumulator / score: sum of up to M unit terms, signed.
    function automatic int unsigned acc2_w(input int unsigned m);
        return $clog2(m) + 2;
    endfunction

    // LSB-first field extraction: entry idx of width w sits at [idx*w +: w].
    function automatic int unsigned field(input logic [VEC_MAX-1:0] vec,
                                          input int unsigned idx,
                                          input int unsigned w);
        logic [VEC_MAX-1:0] sh;
        sh = vec >> (idx * w);
        return sh[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/tnn_csr_seq_hs_csr_row_walker.sv
// Walks one compile-time CSR matrix: one nonzero or one row commit per step.
module csr_row_walker
    import tnn_pkg::*;
#(
    parameter int unsigned ROWS = 2,
    parameter int unsigned COLS = 2,
    parameter int unsigned NNZ  = 3,
    parameter logic [NNZ-1:0]                   VALS   = '0,
    parameter logic [NNZ*idx_w(COLS)-1:0]       COL    = '0,
    parameter logic [(ROWS+1)*ptr_w(NNZ)-1:0]   ROWPTR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       step,
    output logic [idx_w(COLS)-1:0]     col,
    output logic                       sign,
    output logic                       commit,
    output logic [$clog2(ROWS+1)-1:0]  row
);

    localparam int unsigned CW = idx_w(COLS);
    localparam int unsigned PW = ptr_w(NNZ);
    localparam int unsigned RW = $clog2(ROWS + 1);

    localparam logic [VEC_MAX-1:0] VALS_X   = VEC_MAX'(VALS);
    localparam logic [VEC_MAX-1:0] COL_X    = VEC_MAX'(COL);
    localparam logic [VEC_MAX-1:0] ROWPTR_X = VEC_MAX'(ROWPTR);
    localparam logic [RW-1:0]      ROWS_R   = RW'(ROWS);

    logic [RW-1:0] row_q;
    logic [PW-1:0] ptr;
    logic [PW-1:0] end_ptr;
    int unsigned   end_idx;

    assign row = row_q;

    // Decode the current nonzero and detect the end of the current row.
    always_comb begin
        end_idx = ROWS;
        if (row_q < ROWS_R) begin
            end_idx = 32'(row_q) + 32'd1;
        end
        end_ptr = PW'(field(ROWPTR_X, end_idx, PW));
        commit  = !(ptr < end_ptr);
        col     = CW'(field(COL_X, 32'(ptr), CW));
        sign    = (field(VALS_X, 32'(ptr), 1) != 32'd0);
    end

    // Row/pointer counters; a commit keeps ptr since it already equals the next row start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            ptr   <= '0;
        end else if (start) begin
            row_q <= '0;
            ptr   <= PW'(field(ROWPTR_X, 0, PW));
        end else if (step) begin
            if (commit) begin
                row_q <= row_q + RW'(1);
            end else begin
                ptr <= ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/tnn_csr_seq_hs.sv
// Sequential two-layer CSR-sparse ternary classifier with valid/ready handshakes.
module tnn_csr_seq_hs
    import tnn_pkg::*;
#(
    parameter int unsigned N    = 11,
    parameter int unsigned B    = 4,
    parameter int unsigned M    = 40,
    parameter int unsigned C    = 7,
    parameter int unsigned NNZ1 = 160,
    parameter int unsigned NNZ2 = 79,
    parameter logic [NNZ1-1:0]                 W1VALS = '0,
    parameter logic [NNZ1*idx_w(N)-1:0]        W1COL  = '0,
    parameter logic [(M+1)*ptr_w(NNZ1)-1:0]    W1ROW  = '0,
    parameter logic [NNZ2-1:0]                 W2VALS = '0,
    parameter logic [NNZ2*idx_w(M)-1:0]        W2COL  = '0,
    parameter logic [(C+1)*ptr_w(NNZ2)-1:0]    W2ROW  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*B-1:0]          data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(C)-1:0]    klass,
    output logic [$clog2(M)+1:0]    score
);

    localparam int unsigned A1W = acc1_w(N, B);
    localparam int unsigned A2W = acc2_w(M);
    localparam int unsigned KW  = $clog2(C);
    localparam int unsigned CW1 = idx_w(N);
    localparam int unsigned CW2 = idx_w(M);
    localparam int unsigned RW1 = $clog2(M + 1);
    localparam int unsigned RW2 = $clog2(C + 1);

    localparam logic [RW1-1:0] M_LAST = RW1'(M - 1);
    localparam logic [RW2-1:0] C_END  = RW2'(C);

    tnn_state_e state, state_next;

    logic [N*B-1:0]        x_reg;
    logic signed [A1W-1:0] acc1;
    logic signed [A1W-1:0] feat_s;
    logic signed [A2W-1:0] acc2;
    logic signed [A2W-1:0] best;
    logic [KW-1:0]         best_idx;
    logic [M-1:0]          hid;
    logic [B-1:0]          feat;
    logic                  hid_bit;

    logic accept, w1_start, w1_step, w2_start, w2_step;

    logic [CW1-1:0] w1_col;
    logic           w1_sign, w1_commit;
    logic [RW1-1:0] w1_row;
    logic [CW2-1:0] w2_col;
    logic           w2_sign, w2_commit;
    logic [RW2-1:0] w2_row;

    csr_row_walker #(
        .ROWS   (M),
        .COLS   (N),
        .NNZ    (NNZ1),
        .VALS   (W1VALS),
        .COL    (W1COL),
        .ROWPTR (W1ROW)
    ) u_walk1 (
        .clk    (clk),
        .rst    (rst),
        .start  (w1_start),
        .step   (w1_step),
        .col    (w1_col),
        .sign   (w1_sign),
        .commit (w1_commit),
        .row    (w1_row)
    );

    csr_row_walker #(
        .ROWS   (C),
        .COLS   (M),
        .NNZ    (NNZ2),
        .VALS   (W2VALS),
        .COL    (W2COL),
        .ROWPTR (W2ROW)
    ) u_walk2 (
        .clk    (clk),
        .rst    (rst),
        .start  (w2_start),
        .step   (w2_step),
        .col    (w2_col),
        .sign   (w2_sign),
        .commit (w2_commit),
        .row    (w2_row)
    );

    // Operand select: input feature for layer 1, hidden bit for layer 2.
    always_comb begin
        feat    = '0;
        hid_bit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w1_col == CW1'(i)) begin
                feat = x_reg[i*B +: B];
            end
        end
        for (int unsigned i = 0; i < M; i++) begin
            if (w2_col == CW2'(i)) begin
                hid_bit = hid[i];
            end
        end
        feat_s = {{(A1W-B){1'b0}}, feat};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and walker control.
    // L2 spends one extra cycle past its last commit (row == C) to latch the winner.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        w1_start   = 1'b0;
        w1_step    = 1'b0;
        w2_start   = 1'b0;
        w2_step    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    w1_start   = 1'b1;
                    state_next = S_L1;
                end
            end
            S_L1: begin
                w1_step = 1'b1;
                if (w1_commit && (w1_row == M_LAST)) begin
                    w2_start   = 1'b1;
                    state_next = S_L2;
                end
            end
            S_L2: begin
                if (w2_row == C_END) begin
                    state_next = S_DONE;
                end else begin
                    w2_step = 1'b1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: input capture, accumulators, hidden shift register, argmax and result latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg    <= '0;
            acc1     <= '0;
            acc2     <= '0;
            best     <= '0;
            best_idx <= '0;
            hid      <= '0;
            klass    <= '0;
            score    <= '0;
        end else begin
            if (accept) begin
                x_reg <= data;
            end
            if (state == S_L1) begin
                if (w1_commit) begin
                    // Rows commit in order, so shifting in at the top leaves row r at hid[r].
                    hid  <= {~acc1[A1W-1], hid[M-1:1]};
                    acc1 <= '0;
                end else if (w1_sign) begin
                    acc1 <= acc1 + feat_s;
                end else begin
                    acc1 <= acc1 - feat_s;
                end
            end
            if (w2_step) begin
                if (w2_commit) begin
                    if ((w2_row == '0) || (acc2 > best)) begin
                        best     <= acc2;
                        best_idx <= KW'(w2_row);
                    end
                    acc2 <= '0;
                end else if (w2_sign == hid_bit) begin
                    acc2 <= acc2 + A2W'(1);
                end else begin
                    acc2 <= acc2 - A2W'(1);
                end
            end
            if ((state == S_L2) && (w2_row == C_END)) begin
                klass <= best_idx;
                score <= best;
            end
        end
    end

endmodule

// File: doc/tnn_csr_seq_hs.md
Name: tnn_csr_seq_hs

Overview:
- Next-generation sequential ternary neural-network classifier.
- Both layers are stored as compile-time CSR-sparse ternary matrices; the current generation has a dense first layer.
- Adds a valid/ready handshake on input and output, plus a winning-score output.
- Instantiated by per-dataset product wrappers. It processes one nonzero weight per cycle.

Parameters:
- N, 11, number of input features.
- B, 4, bits per unsigned feature.
- M, 40, hidden neurons.
- C, 7, classes.
- NNZ1, 160, nonzeros in layer 1 (M rows x N cols).
- NNZ2, 79, nonzeros in layer 2 (C rows x M cols).
- W1VALS, NNZ1 bits, sign per layer-1 nonzero (1 = +1, 0 = -1).
- W1COL, NNZ1*$clog2(N) bits, column index per layer-1 nonzero.
- W1ROW, (M+1)*$clog2(NNZ1+1) bits, row start pointers for layer 1. Entry M must equal NNZ1.
- W2VALS, NNZ2 bits, sign per layer-2 nonzero.
- W2COL, NNZ2*$clog2(M) bits, column index per layer-2 nonzero.
- W2ROW, (C+1)*$clog2(NNZ2+1) bits, row start pointers for layer 2. Entry C must equal NNZ2.
- Packing rule for every vector: entry k occupies [k*W +: W], LSB-first.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  data valid
- in_ready  out  1  block can accept data
- data  in  N*B  packed features; feature i is [i*B +: B]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- klass  out  $clog2(C)  argmax class
- score  out  $clog2(M)+2  signed score of the winning class

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; in_ready=1, out_valid=0, klass=0, score=0.
  - All counters, accumulators and the hidden register clear.
- FSM states: IDLE, L1, L2, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture data into an internal register; row=0, ptr=W1ROW[0]; go to L1.
- L1:
  - Per cycle, if ptr < W1ROW[row+1]: acc1 += (W1VALS[ptr] ? +x[col] : -x[col]); ptr++.
  - Otherwise it is a commit cycle: hid[row] = (acc1 >= 0); acc1 = 0; row++.
  - After the commit of row M-1, reset row and ptr for layer 2 and go to L2.
- L2:
  - Same walk. Hidden bit 1 counts as +1, bit 0 as -1; each nonzero adds ±(hid ? +1 : -1).
  - On each row commit, compare against the best score so far. Update only if strictly greater, so ties go to the lowest class index.
  - Row 0 always initialises the best.
  - After commit of row C-1, latch klass and score and go to DONE.
- DONE:
  - out_valid=1; klass and score held stable.
  - On out_ready, go to IDLE. in_ready rises the following cycle.
- in_ready=0 in L1, L2 and DONE. in_valid asserted while busy is ignored; data is not sampled.
- Latency from the accept edge to the out_valid rising edge is exactly NNZ1 + M + NNZ2 + C + 1 cycles.
- Empty rows:
  - A layer-1 row with no nonzeros costs one commit cycle and gives hidden = 1, since acc = 0.
  - A layer-2 row with no nonzeros gives score 0.
- Arithmetic widths:
  - acc1 is signed, B + $clog2(N+1) + 1 bits.
  - acc2 and best are signed, $clog2(M) + 2 bits.
  - No overflow is possible.
- Asserting rst mid-L1/L2/DONE aborts the inference and discards the result; no out_valid is produced.

Decomposition:
- Shared package tnn_pkg holds:
  - the state enum;
  - width helper functions (index widths, accumulator widths);
  - the LSB-first field extraction function for packed parameter vectors.
- One natural sub-module: csr_row_walker. It holds the row/ptr counters, end-of-row detection, and emits col, sign, commit and last-row.
- Instantiate csr_row_walker once per layer, or time-share a single walker with a layer-select.

Test Plan:
Small config unless stated: N=2, B=4, M=2, C=2.
- L1 rows: row 0 = {c0:+1, c1:-1}; row 1 = {c1:+1}.
- L2 rows: row 0 = {c0:+1, c1:+1}; row 1 = {c0:-1}.
- NNZ1 = 3, NNZ2 = 3; expected latency is 11 cycles.

1. x0=3, x1=5 -> h=(0,1), scores (0,+1) -> klass=1, score=+1, out_valid exactly 11 cycles after the accept edge.
2. x0=5, x1=3 -> h=(1,1), scores (+2,-1) -> klass=0, score=+2.
3. Both x=0 -> h=(1,1), klass=0. Then rewrite L2 row 1 = {c0:+1, c1:+1} so both scores are +2 -> tie resolves to klass=0.
4. Hold out_ready=0 for 20 cycles in DONE -> out_valid, klass and score stable, in_ready=0, and a second in_valid is ignored. Then out_ready=1 -> IDLE, and the next accepted vector is processed correctly.
5. Pulse rst at cycle 5 of L1 -> in_ready=1 and out_valid=0 immediately. The following inference gives the scenario-1 result and latency.
6. Full-size defaults with randomized CSR parameters and 1000 random vectors, compared against a reference model -> klass and score match, and the latency formula holds on every vector.
